mips_mc_control: RTL and testbench

Multi-cycle main control FSM for the 32-bit MIPS datapath. It sequences a shared ALU, a single unified memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps, one instruction at a time. It generates the 2-bit ALUOp consumed by the existing ALU control decoder: 00 = add, 01 = subtract, 10 = decode from funct. Memory accesses use a ready handshake with a timeout.

---
 rtl/mips_ctrl_pkg.sv | 30 +++
 rtl/mips_mem_wait_timer.sv | 24 ++
 rtl/mips_mc_control.sv | 150 +++++++++++++++
 tb/tb_mips_mc_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and ALUOp encodings for the multi-cycle MIPS control.
package mips_ctrl_pkg;
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_MEM_RD = 4'd3;
    localparam logic [3:0] S_WB_MEM = 4'd4;
    localparam logic [3:0] S_MEM_WR = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_WB_R   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_EXEC_I = 4'd10;
    localparam logic [3:0] S_WB_I   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_mem_state(logic [3:0] s);
        return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
    endfunction
endpackage

// File: rtl/mips_mem_wait_timer.sv
// mips_mem_wait_timer: counts unanswered memory-wait cycles and flags a timeout.
module mips_mem_wait_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_waiting,
    input  logic i_ready,
    output logic o_timeout
);
    logic [7:0] r_cnt;

    // ready in the final cycle wins, so the timeout is suppressed by it
    assign o_timeout = i_waiting && !i_ready && r_cnt == 8'(TIMEOUT_CYC - 1);

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_cnt <= '0;
        else if (i_clear || !i_waiting || i_ready || o_timeout)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 8'd1;
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS main control FSM with memory ready/timeout handling.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_timeout;

    mips_mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_clear  (w_next != r_state),
        .i_waiting(is_mem_state(r_state)),
        .i_ready  (mem_ready),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (opcode)
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_LW, OP_SW: w_next = S_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_EXEC_I;
                    default:      w_next = S_FETCH;
                endcase
            S_ADDR:   w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: w_next = mem_ready ? S_WB_MEM : (w_timeout ? S_FETCH : S_MEM_RD);
            S_MEM_WR: w_next = (mem_ready || w_timeout) ? S_FETCH : S_MEM_WR;
            S_EXEC_R: w_next = S_WB_R;
            S_EXEC_I: w_next = S_WB_I;
            default:  w_next = S_FETCH;
        endcase
    end

    // reset overrides everything so a held reset drives an all-zero interface
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALUOP_ADD;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_err       = 1'b0;
        state         = 4'd0;
        if (!reset) begin
            state   = r_state;
            mem_err = w_timeout;
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = (w_next == S_FETCH);
                end
                S_ADDR, S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_WB_MEM: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_WB_R: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: plans each instruction as a cycle sequence and checks the control FSM against it.
module tb_mips_mc_control;
    localparam int TO = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op, mem_err;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       instr_done, illegal_op, mem_err;
    } out_t;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        out_t       o;
    } cyc_t;

    out_t       got;
    cyc_t       q[$];
    logic [5:0] cur_op;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    mips_mc_control #(.TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_err(mem_err), .state(state)
    );

    assign got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op, mem_err};

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, act, exp);
        end
    endtask

    // static datapath controls of each step; completion flags are added by the planner
    function automatic out_t ref_out(int st, logic rdy);
        out_t o = '0;
        case (st)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.i_or_d = 1; end
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            5:  begin o.mem_write = 1; o.i_or_d = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_dst = 1; o.reg_write = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            11: o.reg_write = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic void push(int st, logic rdy, logic done, logic ill, logic err);
        cyc_t c;
        c.st = 4'(st);
        c.rdy = rdy;
        c.o = ref_out(st, rdy);
        c.o.instr_done = done;
        c.o.illegal_op = ill;
        c.o.mem_err = err;
        q.push_back(c);
    endfunction

    // w wait cycles then ready; returns 0 if the wait is long enough to time out
    function automatic bit mem_phase(int st, int w, logic last);
        for (int i = 0; i < w && i < TO; i++) push(st, 1'b0, 1'b0, 1'b0, i == TO - 1);
        if (w >= TO) return 0;
        push(st, 1'b1, last, 1'b0, 1'b0);
        return 1;
    endfunction

    function automatic void plan(logic [5:0] op, int fw, int mw);
        while (!mem_phase(0, fw, 1'b0)) fw = 0;
        case (op)
            6'b000000: begin push(1, rb(), 0, 0, 0); push(6, rb(), 0, 0, 0); push(7, rb(), 1, 0, 0); end
            6'b100011: begin
                push(1, rb(), 0, 0, 0); push(2, rb(), 0, 0, 0);
                if (mem_phase(3, mw, 1'b0)) push(4, rb(), 1, 0, 0);
            end
            6'b101011: begin
                push(1, rb(), 0, 0, 0); push(2, rb(), 0, 0, 0);
                void'(mem_phase(5, mw, 1'b1));
            end
            6'b000100: begin push(1, rb(), 0, 0, 0); push(8, rb(), 1, 0, 0); end
            6'b000010: begin push(1, rb(), 0, 0, 0); push(9, rb(), 1, 0, 0); end
            6'b001000: begin push(1, rb(), 0, 0, 0); push(10, rb(), 0, 0, 0); push(11, rb(), 1, 0, 0); end
            default:   push(1, rb(), 0, 1, 0);
        endcase
    endfunction

    // entered at a falling edge; IR contents are noise while fetching
    task automatic run_q();
        foreach (q[i]) begin
            opcode = (q[i].st == 4'd0) ? 6'($urandom) : cur_op;
            mem_ready = q[i].rdy;
            #1;
            check("state", 32'(state), 32'(q[i].st));
            check("outs", 32'(got), 32'(q[i].o));
            @(negedge clock);
        end
        q.delete();
    endtask

    task automatic do_instr(logic [5:0] op, int fw, int mw);
        cur_op = op;
        plan(op, fw, mw);
        run_q();
    endtask

    function automatic bit legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    initial begin
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        repeat (2) @(negedge clock);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'(got), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        do_instr(6'b100011, 0, 0);
        do_instr(6'b101011, 0, 3);
        do_instr(6'b000000, 0, 0);
        do_instr(6'b000100, 0, 0);
        do_instr(6'b000010, 0, 0);
        do_instr(6'b111111, 0, 0);
        do_instr(6'b100011, 0, 4);
        do_instr(6'b101011, 0, 4);
        do_instr(6'b100011, 2, 1);
        do_instr(6'b001000, 4, 0);
        // asynchronous reset inside WB_R, observed before the next rising edge
        cur_op = 6'b000000;
        push(0, 1, 0, 0, 0);
        push(1, 1, 0, 0, 0);
        push(6, 1, 0, 0, 0);
        run_q();
        opcode = 6'b000000;
        mem_ready = 1'b1;
        #1;
        check("wbr_state", 32'(state), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_outs", 32'(got), 32'd0);
        @(negedge clock);
        #1;
        check("arst_hold", 32'(got), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        do_instr(6'b000000, 0, 0);
        repeat (300) begin
            if ($urandom_range(7) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(5)];
            end
            do_instr(op, ($urandom_range(5) == 0) ? int'($urandom_range(TO)) : 0,
                     int'($urandom_range(TO + 1)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
